// File: rtl/ptp_event_sequencer_if.sv
// MAC-side IEEE 1588 event strobes (single-cycle pulses, clk domain).
interface ieee1588_if;
  logic sof_tx;
  logic sof_rx;
  logic syncframe_tx;
  logic syncframe_rx;
  logic delayreq_tx;
  logic delayreq_rx;
  logic pdelayreq_tx;
  logic pdelayreq_rx;
  logic pdelayresp_tx;
  logic pdelayresp_rx;

  modport master (
    output sof_tx, sof_rx, syncframe_tx, syncframe_rx, delayreq_tx, delayreq_rx,
           pdelayreq_tx, pdelayreq_rx, pdelayresp_tx, pdelayresp_rx
  );

  modport slave (
    input sof_tx, sof_rx, syncframe_tx, syncframe_rx, delayreq_tx, delayreq_rx,
          pdelayreq_tx, pdelayreq_rx, pdelayresp_tx, pdelayresp_rx
  );
endinterface

// File: rtl/ptp_event_sequencer.sv
// Timestamps TX/RX start-of-frame events, classifies PTP frames and queues them in an event FIFO.
// Optional PTP_LOG_ALL_SOF_EN: unclassified (timed-out or restarted) frames are also queued as type 0.
module ptp_event_sequencer #(
  parameter int unsigned TS_WIDTH        = 32,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned CLASSIFY_WINDOW = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ieee1588_if.slave                    ptp,
  input  logic                         ts_clear,
  input  logic                         ovf_clear,
  output logic [TS_WIDTH-1:0]          ts_now,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic                         evt_dir,
  output logic [2:0]                   evt_type,
  output logic [TS_WIDTH-1:0]          evt_ts,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned WW = 8;

  localparam logic [2:0] T_SOF         = 3'd0;
  localparam logic [2:0] T_SYNC        = 3'd1;
  localparam logic [2:0] T_DELAY_REQ   = 3'd2;
  localparam logic [2:0] T_PDELAY_REQ  = 3'd3;
  localparam logic [2:0] T_PDELAY_RESP = 3'd4;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic                dir;
    logic [2:0]          typ;
    logic [TS_WIDTH-1:0] ts;
  } evt_t;

  logic [1:0]          sof, sync, dreq, pdreq, presp, has_strobe;
  logic [2:0]          strobe_type [2];
  state_t              state       [2];
  logic [WW-1:0]       win         [2];
  logic [TS_WIDTH-1:0] ts_lat      [2];
  logic [1:0]          cls_fire;
  logic [2:0]          cls_type    [2];
  logic [TS_WIDTH-1:0] cls_ts      [2];
  logic [1:0]          pend_valid;
  evt_t                pend        [2];
  logic [1:0]          grant;
  logic                last_grant;
  evt_t                wr_entry;
  logic                pop, full, wr_en, drop, ovf_set;
  evt_t                mem         [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]       level_nxt;
  evt_t                head_nxt;

  // Free-running timestamp counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ts_now <= '0;
    else if (ts_clear) ts_now <= '0;
    else               ts_now <= ts_now + TS_WIDTH'(1);
  end

  // Strobe decode with SYNC > DELAY_REQ > PDELAY_REQ > PDELAY_RESP priority
  always_comb begin
    sof   = {ptp.sof_rx,        ptp.sof_tx};
    sync  = {ptp.syncframe_rx,  ptp.syncframe_tx};
    dreq  = {ptp.delayreq_rx,   ptp.delayreq_tx};
    pdreq = {ptp.pdelayreq_rx,  ptp.pdelayreq_tx};
    presp = {ptp.pdelayresp_rx, ptp.pdelayresp_tx};
    for (int d = 0; d < 2; d++) begin
      has_strobe[d] = sync[d] | dreq[d] | pdreq[d] | presp[d];
      if (sync[d])       strobe_type[d] = T_SYNC;
      else if (dreq[d])  strobe_type[d] = T_DELAY_REQ;
      else if (pdreq[d]) strobe_type[d] = T_PDELAY_REQ;
      else               strobe_type[d] = T_PDELAY_RESP;
    end
  end

  // Classification result per direction for this cycle
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      cls_fire[d] = 1'b0;
      cls_type[d] = T_SOF;
      cls_ts[d]   = ts_now;
      if (has_strobe[d] && (sof[d] || state[d] == WAIT)) begin
        cls_fire[d] = 1'b1;
        cls_type[d] = strobe_type[d];
        cls_ts[d]   = sof[d] ? ts_now : ts_lat[d];
      end
`ifdef PTP_LOG_ALL_SOF_EN
      else if (state[d] == WAIT && (sof[d] || win[d] == WW'(1))) begin
        cls_fire[d] = 1'b1;
        cls_type[d] = T_SOF;
        cls_ts[d]   = ts_lat[d];
      end
`endif
    end
  end

  // Per-direction capture FSM; window counts down from CLASSIFY_WINDOW to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        state[d]  <= IDLE;
        win[d]    <= '0;
        ts_lat[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (state[d])
          IDLE: begin
            if (sof[d] && !has_strobe[d]) begin
              state[d]  <= WAIT;
              win[d]    <= WW'(CLASSIFY_WINDOW);
              ts_lat[d] <= ts_now;
            end
          end
          WAIT: begin
            if (has_strobe[d]) begin
              state[d] <= IDLE;
            end else if (sof[d]) begin
              win[d]    <= WW'(CLASSIFY_WINDOW);
              ts_lat[d] <= ts_now;
            end else if (win[d] == WW'(1)) begin
              state[d] <= IDLE;
            end else begin
              win[d] <= win[d] - WW'(1);
            end
          end
          default: state[d] <= IDLE;
        endcase
      end
    end
  end

  // Pending registers: a new classification replaces any entry still waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= '0;
      for (int d = 0; d < 2; d++) pend[d] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (cls_fire[d]) begin
          pend_valid[d] <= 1'b1;
          pend[d]       <= '{dir: d[0], typ: cls_type[d], ts: cls_ts[d]};
        end else if (grant[d]) begin
          pend_valid[d] <= 1'b0;
        end
      end
    end
  end

  // Round-robin arbiter; last_grant=0 means TX won last, so RX wins the next tie
  always_comb begin
    if (pend_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    else                     grant = pend_valid;
    wr_entry  = grant[1] ? pend[1] : pend[0];
    pop       = evt_valid && evt_ready;
    full      = (fifo_level == LW'(FIFO_DEPTH));
    wr_en     = (|grant) && (!full || pop);
    drop      = (|grant) && full && !pop;
    ovf_set   = drop || (|(cls_fire & pend_valid & ~grant));
    rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_nxt = fifo_level + LW'(wr_en) - LW'(pop);
    head_nxt  = (wr_en && wr_ptr == rd_nxt) ? wr_entry : mem[rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (|grant)         last_grant <= grant[1];
      if (ovf_set)        overflow   <= 1'b1;
      else if (ovf_clear) overflow   <= 1'b0;
    end
  end

  // Event FIFO with registered head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      evt_valid  <= 1'b0;
      evt_dir    <= 1'b0;
      evt_type   <= '0;
      evt_ts     <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_nxt;
      fifo_level <= level_nxt;
      evt_valid  <= (level_nxt != '0);
      if (level_nxt != '0) begin
        evt_dir  <= head_nxt.dir;
        evt_type <= head_nxt.typ;
        evt_ts   <= head_nxt.ts;
      end
    end
  end

endmodule

// File: tb/tb_ptp_event_sequencer.sv
// Directed self-checking bench for ptp_event_sequencer (TS_WIDTH=16, FIFO_DEPTH=8, window 8).
// Expectations follow PTP_LOG_ALL_SOF_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_ptp_event_sequencer;

  localparam int unsigned TSW = 16;
  localparam int unsigned DEP = 8;
  localparam int unsigned W   = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ts_clear, ovf_clear, evt_ready;
  logic [TSW-1:0] ts_now, evt_ts;
  logic           evt_valid, evt_dir, overflow;
  logic [2:0]     evt_type;
  logic [3:0]     fifo_level;

  int checks = 0;
  int errors = 0;

  ieee1588_if ptp_bus ();

  ptp_event_sequencer #(.TS_WIDTH(TSW), .FIFO_DEPTH(DEP), .CLASSIFY_WINDOW(W)) dut (
    .clk(clk), .rst_n(rst_n), .ptp(ptp_bus), .ts_clear(ts_clear), .ovf_clear(ovf_clear),
    .ts_now(ts_now), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_dir(evt_dir),
    .evt_type(evt_type), .evt_ts(evt_ts), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ts(input logic [TSW-1:0] target);
    int n = 0;
    while (ts_now !== target && n < 70000) begin
      tick();
      n++;
    end
    chk("wait_ts", 32'(ts_now), 32'(target));
  endtask

  task automatic set_strobes(input logic rx, input logic [4:0] v);
    if (rx) begin
      {ptp_bus.sof_rx, ptp_bus.syncframe_rx, ptp_bus.delayreq_rx,
       ptp_bus.pdelayreq_rx, ptp_bus.pdelayresp_rx} = v;
    end else begin
      {ptp_bus.sof_tx, ptp_bus.syncframe_tx, ptp_bus.delayreq_tx,
       ptp_bus.pdelayreq_tx, ptp_bus.pdelayresp_tx} = v;
    end
  endtask

  task automatic clear_strobes;
    set_strobes(1'b0, 5'b0);
    set_strobes(1'b1, 5'b0);
  endtask

  // Count popped events over a number of cycles (evt_ready held high)
  task automatic collect(input int cycles, output int cnt, output logic dir,
                         output logic [2:0] typ, output logic [TSW-1:0] ts);
    cnt = 0; dir = 1'b0; typ = 3'd7; ts = '0;
    for (int i = 0; i < cycles; i++) begin
      if (evt_valid && evt_ready) begin
        cnt++;
        dir = evt_dir; typ = evt_type; ts = evt_ts;
      end
      tick();
    end
  endtask

  initial begin
    int             cnt;
    logic           cdir;
    logic [2:0]     ctyp;
    logic [TSW-1:0] cts, t0;
    logic [4:0]     pv [5];
    logic [2:0]     pe [5];

    rst_n = 1'b0; ts_clear = 1'b0; ovf_clear = 1'b0; evt_ready = 1'b1;
    clear_strobes();
    #12;
    chk("rst_ts_now", 32'(ts_now), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_fields", {evt_dir, evt_type, evt_ts}, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    ts_clear = 1'b1;
    tick();
    ts_clear = 1'b0;
    chk("ts_clear", 32'(ts_now), 32'd0);

    // TX SOF at 100, SYNC five cycles later
    wait_ts(16'd100);
    ptp_bus.sof_tx = 1'b1;
    tick();
    ptp_bus.sof_tx = 1'b0;
    repeat (4) tick();
    ptp_bus.syncframe_tx = 1'b1;
    tick();
    ptp_bus.syncframe_tx = 1'b0;
    chk("t1_valid_k1", 32'(evt_valid), 32'd0);
    tick();
    chk("t1_valid_k2", 32'(evt_valid), 32'd1);
    chk("t1_event", {evt_dir, evt_type, evt_ts}, {1'b0, 3'd1, 16'd100});
    tick();
    chk("t1_empty", 32'(evt_valid), 32'd0);

    // Simultaneous TX/RX PDELAY_REQ with SOF at 200: RX first
    wait_ts(16'd200);
    set_strobes(1'b0, 5'b10010);
    set_strobes(1'b1, 5'b10010);
    tick();
    clear_strobes();
    chk("t2_valid_k1", 32'(evt_valid), 32'd0);
    tick();
    chk("t2_first", {evt_valid, evt_dir, evt_type, evt_ts}, {1'b1, 1'b1, 3'd3, 16'd200});
    tick();
    chk("t2_second", {evt_valid, evt_dir, evt_type, evt_ts}, {1'b1, 1'b0, 3'd3, 16'd200});
    tick();
    chk("t2_empty", 32'(evt_valid), 32'd0);

    // Type priority on RX, SOF and strobes in the same cycle
    pv[0] = 5'b11001; pe[0] = 3'd1;
    pv[1] = 5'b10110; pe[1] = 3'd2;
    pv[2] = 5'b10011; pe[2] = 3'd3;
    pv[3] = 5'b10001; pe[3] = 3'd4;
    pv[4] = 5'b11111; pe[4] = 3'd1;
    for (int i = 0; i < 5; i++) begin
      set_strobes(1'b1, pv[i]);
      tick();
      clear_strobes();
      tick();
      chk("prio_event", {evt_valid, evt_dir, evt_type}, {1'b1, 1'b1, pe[i]});
      tick();
    end

    // RX SOF then no strobe: timeout
    t0 = ts_now;
    ptp_bus.sof_rx = 1'b1;
    tick();
    ptp_bus.sof_rx = 1'b0;
    collect(W + 4, cnt, cdir, ctyp, cts);
`ifdef PTP_LOG_ALL_SOF_EN
    chk("timeout_cnt", 32'(cnt), 32'd1);
    chk("timeout_evt", {cdir, ctyp, cts}, {1'b1, 3'd0, t0});
`else
    chk("timeout_cnt", 32'(cnt), 32'd0);
`endif

    // Strobe exactly W cycles after SOF is accepted
    t0 = ts_now;
    ptp_bus.sof_tx = 1'b1;
    tick();
    ptp_bus.sof_tx = 1'b0;
    repeat (W - 1) tick();
    ptp_bus.delayreq_tx = 1'b1;
    tick();
    ptp_bus.delayreq_tx = 1'b0;
    collect(4, cnt, cdir, ctyp, cts);
    chk("win_edge_cnt", 32'(cnt), 32'd1);
    chk("win_edge_evt", {cdir, ctyp, cts}, {1'b0, 3'd2, t0});

    // Strobe W+1 cycles after SOF is ignored
    t0 = ts_now;
    ptp_bus.sof_tx = 1'b1;
    tick();
    ptp_bus.sof_tx = 1'b0;
    repeat (W) tick();
    ptp_bus.delayreq_tx = 1'b1;
    tick();
    ptp_bus.delayreq_tx = 1'b0;
    collect(6, cnt, cdir, ctyp, cts);
`ifdef PTP_LOG_ALL_SOF_EN
    chk("win_late_cnt", 32'(cnt), 32'd1);
    chk("win_late_evt", {cdir, ctyp, cts}, {1'b0, 3'd0, t0});
`else
    chk("win_late_cnt", 32'(cnt), 32'd0);
`endif

    // Nine back-to-back events into a stalled 8-deep FIFO
    evt_ready = 1'b0;
    t0 = ts_now;
    set_strobes(1'b0, 5'b11000);
    repeat (9) tick();
    clear_strobes();
    tick();
    tick();
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_head_stable", 32'(evt_ts), 32'(t0));
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(evt_valid), 32'd1);
      chk("drain_ts", 32'(evt_ts), 32'(t0 + 16'(i)));
      tick();
    end
    chk("drain_empty", {evt_valid, fifo_level}, 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Counter wrap: SOF at 0xFFFF, DELAY_REQ two cycles later
    wait_ts(16'hFFFF);
    ptp_bus.sof_tx = 1'b1;
    tick();
    ptp_bus.sof_tx = 1'b0;
    chk("wrap_zero", 32'(ts_now), 32'd0);
    tick();
    chk("wrap_one", 32'(ts_now), 32'd1);
    ptp_bus.delayreq_tx = 1'b1;
    tick();
    ptp_bus.delayreq_tx = 1'b0;
    tick();
    chk("wrap_event", {evt_valid, evt_dir, evt_type, evt_ts}, {1'b1, 1'b0, 3'd2, 16'hFFFF});
    tick();

    // Asynchronous reset with three queued entries and TX in WAIT
    evt_ready = 1'b0;
    set_strobes(1'b0, 5'b11000);
    repeat (3) tick();
    set_strobes(1'b0, 5'b10000);
    tick();
    clear_strobes();
    tick();
    tick();
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(evt_valid), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ts", 32'(ts_now), 32'd0);
    tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    tick();
    ptp_bus.syncframe_tx = 1'b1;
    tick();
    ptp_bus.syncframe_tx = 1'b0;
    collect(4, cnt, cdir, ctyp, cts);
    chk("post_rst_no_evt", 32'(cnt), 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptp_event_sequencer.md
# ptp_event_sequencer

Timestamps and sequences the IEEE 1588 frame events reported by the Zynq GEM MAC through `ieee1588_if`. The block latches a free-running cycle counter on every TX/RX start-of-frame and classifies the frame from the PTP type strobe that follows. It arbitrates the two directions into one event FIFO and presents the entries on a valid/ready read port to the PTP software/AXI register block.

## Interface
- `TS_WIDTH`, 32: timestamp counter width in bits, 16..64.
- `FIFO_DEPTH`, 8: number of event FIFO entries; power of two, 2..64.
- `CLASSIFY_WINDOW`, 64: cycles after SOF during which a type strobe is accepted; 1..255.
- `clk` in 1: single clock; all logic in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ptp` in `ieee1588_if`: MAC event strobes, `SOF*`, `SYNCFRAME*`, `DELAYREQ*`, `PDELAYREQ*`, `PDELAYRESP*` for TX and RX. These are single-cycle pulses, synchronous to `clk`.
- `ts_clear` in 1: zeroes the timestamp counter.
- `ovf_clear` in 1: clears `overflow`.
- `ts_now` out TS_WIDTH: current counter value.
- `evt_valid` out 1: FIFO head is valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_dir` out 1: 0 = TX, 1 = RX.
- `evt_type` out 3: 0 = SOF only, 1 = SYNC, 2 = DELAY_REQ, 3 = PDELAY_REQ, 4 = PDELAY_RESP.
- `evt_ts` out TS_WIDTH: timestamp latched at SOF.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `overflow` out 1: sticky flag; an event was lost.

## Operation
- Counter: increments every cycle and wraps from all-ones to 0. If `ts_clear` is high, the counter reads 0 in the next cycle.
- Per direction, an FSM has two states, IDLE and WAIT:
  - IDLE + SOF: latch `ts_now` (the value present in the SOF cycle), load the window counter with CLASSIFY_WINDOW, and go to WAIT.
  - WAIT + type strobe: write {dir, type, ts} into that direction's pending register and go to IDLE.
  - WAIT + window counter reaching 0 with no strobe: the frame is non-PTP; go to IDLE.
  - WAIT + SOF: restart the capture. Re-latch ts, reload the window, no event.
  - A type strobe in the same cycle as SOF (from IDLE or WAIT) classifies immediately. The timestamp is the counter value in that cycle.
  - A type strobe in IDLE without SOF is ignored.
- Type priority when several strobes are high in one cycle: SYNC > DELAY_REQ > PDELAY_REQ > PDELAY_RESP.
- Pending register:
  - Holds one entry per direction.
  - A new classification while the old entry is still pending overwrites it and sets `overflow`.
- Arbiter:
  - At most one FIFO write per cycle.
  - When both pending registers are valid, grant round-robin. The last-grant pointer resets to TX, so RX wins the first tie.
  - The losing entry stays pending and retries next cycle.
- FIFO full: a granted entry with no space is dropped, its pending register is cleared, and `overflow` is set.
  - Full with a simultaneous read (`evt_valid && evt_ready`): the write is accepted and the level is unchanged.
- Read port: the head is stable while `evt_valid && !evt_ready`. The pop happens on `evt_valid && evt_ready`.
- `overflow`: set has priority over `ovf_clear` in the same cycle.

## Timing
- Reset values: `ts_now`=0, `evt_valid`=0, `evt_dir`=0, `evt_type`=0, `evt_ts`=0, `fifo_level`=0, `overflow`=0. Both FSMs in IDLE, pending registers empty, last-grant pointer = TX.
- Latency with an empty FIFO and no contention:
  - Type strobe in cycle k sets pending valid in cycle k+1.
  - The FIFO write happens at the end of cycle k+1.
  - `evt_valid` is high in cycle k+2.
- Contention adds one cycle for the losing direction.
- Throughput: one event per cycle in, one per cycle out.
- Window: a strobe exactly CLASSIFY_WINDOW cycles after SOF is accepted; one cycle later it is ignored.
- Reset asserted mid-operation immediately clears all state, including FIFO contents. Outputs take their reset values asynchronously.

## Configuration
- `PTP_LOG_ALL_SOF_EN` defined: a window timeout in WAIT enqueues {dir, type 0, ts} through the pending register, the same as a classified event. A SOF restart in WAIT also enqueues the abandoned frame as type 0.
- Not defined: timeouts and restarts produce no event, and type 0 never appears on `evt_type`.

## Test plan
- TX SOF at `ts_now`=100, TX SYNC 5 cycles later, `evt_ready`=1 → one event {dir 0, type 1, ts 100}, `evt_valid` 2 cycles after the SYNC strobe.
- RX SOF at ts 200 and TX SOF at ts 200, both followed by PDELAY_REQ in the same cycle → RX event pops first, then TX, on consecutive cycles; both ts=200.
- RX SOF with no strobe for CLASSIFY_WINDOW+1 cycles → no event. With `PTP_LOG_ALL_SOF_EN` → {1, 0, ts}.
- `evt_ready`=0, 9 classified events with FIFO_DEPTH=8 → `fifo_level`=8, `overflow`=1, and the first 8 timestamps drain in order. `ovf_clear` then returns `overflow` to 0.
- TS_WIDTH=16, counter preset near 0xFFFE, SOF at 0xFFFF, DELAY_REQ 2 cycles later → ts=0xFFFF, `ts_now` wraps to 1.
- `rst_n` pulsed low with 3 FIFO entries and TX in WAIT → `evt_valid`=0 and `fifo_level`=0 immediately. A later type strobe without SOF gives no event.
